fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl_adder.sv | 12 +
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INC  = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISCARD,
      DELIVER
   } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus: request/address out, ack/data back in the same cycle.
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int unsigned N = 64
) ();

   logic               imem_req;
   logic [N-1:0]       imem_addr_F;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr_F,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr_F,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_ctrl_adder.sv
// Plain N-bit adder; the sum wraps modulo 2^N.
module fetch_ctrl_adder #(
   parameter int unsigned N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, branch redirects,
// and a single-entry hold register toward decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               PCSrc_F,
   input  logic [N-1:0]       PCBranch_F,
   input  logic               stall_D,
   fetch_ctrl_if.master       imem,
   output logic [INSTR_W-1:0] instr_F,
   output logic [N-1:0]       pc_F,
   output logic               instr_valid_F
);

   fetch_state_t       state_q, state_d;
   logic [N-1:0]       pc_q, pc_d;
   logic [N-1:0]       addr_q, addr_d;
   logic               req_q, req_d;
   logic [INSTR_W-1:0] instr_d;
   logic [N-1:0]       pc_f_d;
   logic               valid_d;
   logic               load_addr;
   logic [N-1:0]       pc_inc;
   logic [N-1:0]       target;

   // Redirect targets are word aligned regardless of the low bits presented.
   assign target = PCBranch_F & ~(N'(3));

   fetch_ctrl_adder #(
      .N (N)
   ) u_pc_inc (
      .a   (addr_q),
      .b   (N'(PC_INC)),
      .sum (pc_inc)
   );

   assign imem.imem_req    = req_q;
   assign imem.imem_addr_F = addr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= '0;
         addr_q        <= '0;
         req_q         <= 1'b0;
         instr_F       <= '0;
         pc_F          <= '0;
         instr_valid_F <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         addr_q        <= addr_d;
         req_q         <= req_d;
         instr_F       <= instr_d;
         pc_F          <= pc_f_d;
         instr_valid_F <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      instr_d   = instr_F;
      pc_f_d    = pc_F;
      valid_d   = instr_valid_F;
      load_addr = 1'b0;

      case (state_q)
         IDLE: begin
            state_d   = FETCH;
            load_addr = 1'b1;
         end
         FETCH: begin
            if (imem.imem_ack) begin
               if (PCSrc_F) begin
                  pc_d      = target;
                  load_addr = 1'b1;
               end else begin
                  instr_d = imem.imem_rdata;
                  pc_f_d  = addr_q;
                  valid_d = 1'b1;
                  pc_d    = pc_inc;
                  state_d = DELIVER;
               end
            end else if (PCSrc_F) begin
               // Request stays on the bus until acked; its data is dropped later.
               pc_d    = target;
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (PCSrc_F) begin
               pc_d = target;
            end
            if (imem.imem_ack) begin
               state_d   = FETCH;
               load_addr = 1'b1;
            end
         end
         DELIVER: begin
            if (PCSrc_F) begin
               pc_d      = target;
               valid_d   = 1'b0;
               state_d   = FETCH;
               load_addr = 1'b1;
            end else if (!stall_D) begin
               valid_d   = 1'b0;
               state_d   = FETCH;
               load_addr = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new request always presents the PC value being written this cycle.
      if (load_addr) begin
         addr_d = pc_d;
      end
      req_d = (state_d == FETCH) || (state_d == DISCARD);
   end

endmodule
